// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Purpose:
//    UART transmit framer. Accepts one DATA_W-bit word on a valid/ready
//    handshake and serialises it on tx as:
//       start(0), data LSB first, optional parity bit, one or two stop bits(1).
//    Parity is generated internally (odd, even, mark, space or none).
//    Sits between a TX buffer and the tx pad.
//
// Parameters:
//    DATA_W        data bits per frame, 5..9
//    CLKS_PER_BIT  clk cycles per serial bit, >= 2
//
// Ports:
//    clk          in   system clock, all logic on rising edge
//    rst          in   asynchronous, active-low reset
//    in_data      in   word to send, sampled on accept
//    in_valid     in   in_data valid
//    in_ready     out  framer can accept (high only in IDLE)
//    parity_type  in   000 none, 001 odd, 010 even, 100 mark, 101 space,
//                      others none; sampled on accept
//    stop_bits    in   0: one stop bit, 1: two stop bits; sampled on accept
//    tx           out  serial line, idle high, registered
//    busy         out  high while a frame is in progress
//    frame_done   out  one-cycle pulse when the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_framer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        parity_type,
   input  logic              stop_bits,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W) + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t              state_reg,    state_next;
   logic [CNT_W-1:0]    cnt_reg,      cnt_next;
   logic [IDX_W-1:0]    idx_reg,      idx_next;
   logic [DATA_W-1:0]   shift_reg,    shift_next;
   logic                par_en_reg,   par_en_next;
   logic                par_bit_reg,  par_bit_next;
   logic                two_stop_reg, two_stop_next;
   logic                tx_reg,       tx_next;
   logic                done_reg,     done_next;

   // Parity for the word currently offered on in_data; only used on accept,
   // so the frame never depends on inputs after the accept edge.
   logic                acc_par_en;
   logic                acc_par_bit;

   logic                accept;
   logic                bit_end;
   logic                last_stop;

   assign accept    = in_valid && (state_reg == S_IDLE);
   assign bit_end   = (cnt_reg == CNT_LAST);
   // idx_reg counts stop bits while in STOP: the first stop bit is the last
   // one unless two were requested.
   assign last_stop = ~two_stop_reg | idx_reg[0];

   always_comb begin
      acc_par_en  = 1'b0;
      acc_par_bit = 1'b0;
      case (parity_type)
         3'b001: begin
            acc_par_en  = 1'b1;
            acc_par_bit = ~^in_data;
         end
         3'b010: begin
            acc_par_en  = 1'b1;
            acc_par_bit = ^in_data;
         end
         3'b100: begin
            acc_par_en  = 1'b1;
            acc_par_bit = 1'b1;
         end
         3'b101: begin
            acc_par_en  = 1'b1;
            acc_par_bit = 1'b0;
         end
         default: begin
            acc_par_en  = 1'b0;
            acc_par_bit = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      idx_next      = idx_reg;
      shift_next    = shift_reg;
      par_en_next   = par_en_reg;
      par_bit_next  = par_bit_reg;
      two_stop_next = two_stop_reg;
      done_next     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next    = S_START;
               cnt_next      = '0;
               idx_next      = '0;
               shift_next    = in_data;
               par_en_next   = acc_par_en;
               par_bit_next  = acc_par_bit;
               two_stop_next = stop_bits;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_next = S_DATA;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               // The LSB of the shift register is always the bit on the line.
               shift_next = {1'b0, shift_reg[DATA_W-1:1]};
               if (idx_reg == IDX_LAST) begin
                  state_next = par_en_reg ? S_PARITY : S_STOP;
                  idx_next   = '0;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_next = S_STOP;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               cnt_next = '0;
               if (last_stop) begin
                  state_next = S_IDLE;
                  idx_next   = '0;
                  done_next  = 1'b1;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // tx is registered from the next state so the line level changes on the
   // same edge as the state: low on the first cycle after accept, and already
   // high in the cycle frame_done is asserted.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_next[0];
         S_PARITY: tx_next = par_bit_reg;
         default:  tx_next = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         shift_reg    <= '0;
         par_en_reg   <= 1'b0;
         par_bit_reg  <= 1'b0;
         two_stop_reg <= 1'b0;
         tx_reg       <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         idx_reg      <= idx_next;
         shift_reg    <= shift_next;
         par_en_reg   <= par_en_next;
         par_bit_reg  <= par_bit_next;
         two_stop_reg <= two_stop_next;
         tx_reg       <= tx_next;
         done_reg     <= done_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign tx         = tx_reg;
   assign frame_done = done_reg;
   assign busy       = (state_reg != S_IDLE);
   assign in_ready   = (state_reg == S_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Self-checking bench for uart_tx_framer. Two instances: DATA_W=8 with
// CLKS_PER_BIT=4, and DATA_W=7 with CLKS_PER_BIT=2. Each accepted word is
// pushed to a scoreboard queue; the captured tx waveform is compared with a
// frame built by a small reference model when the frame completes.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

   typedef struct {
      logic [8:0] data;
      logic [2:0] pt;
      logic       sb;
      bit         sel7;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   // DATA_W=8, CLKS_PER_BIT=4 instance
   logic [7:0] d8_data  = '0;
   logic       d8_valid = 1'b0;
   logic [2:0] d8_pt    = '0;
   logic       d8_sb    = 1'b0;
   logic       rdy8, tx8, busy8, done8;

   // DATA_W=7, CLKS_PER_BIT=2 instance
   logic [6:0] d7_data  = '0;
   logic       d7_valid = 1'b0;
   logic [2:0] d7_pt    = '0;
   logic       d7_sb    = 1'b0;
   logic       rdy7, tx7, busy7, done7;

   uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (d8_data),
      .in_valid   (d8_valid),
      .in_ready   (rdy8),
      .parity_type(d8_pt),
      .stop_bits  (d8_sb),
      .tx         (tx8),
      .busy       (busy8),
      .frame_done (done8)
   );

   uart_tx_framer #(.DATA_W(7), .CLKS_PER_BIT(2)) dut7 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (d7_data),
      .in_valid   (d7_valid),
      .in_ready   (rdy7),
      .parity_type(d7_pt),
      .stop_bits  (d7_sb),
      .tx         (tx7),
      .busy       (busy7),
      .frame_done (done7)
   );

   function automatic logic tx_of(input bit s);
      return s ? tx7 : tx8;
   endfunction

   function automatic logic busy_of(input bit s);
      return s ? busy7 : busy8;
   endfunction

   function automatic logic rdy_of(input bit s);
      return s ? rdy7 : rdy8;
   endfunction

   function automatic logic done_of(input bit s);
      return s ? done7 : done8;
   endfunction

   // Reference frame: bit 0 is the start bit, then data LSB first, parity,
   // stop bit(s). n is the number of bit times in the frame.
   function automatic void model(input exp_t e, output logic [15:0] b, output int n);
      int   dw;
      int   ones;
      logic p;
      bit   pe;
      dw   = e.sel7 ? 7 : 8;
      ones = 0;
      b    = '0;
      n    = 1;
      for (int i = 0; i < dw; i++) begin
         b[n] = e.data[i];
         if (e.data[i]) ones++;
         n++;
      end
      pe = 1'b1;
      p  = 1'b0;
      case (e.pt)
         3'b001:  p = ((ones % 2) == 0);
         3'b010:  p = ((ones % 2) == 1);
         3'b100:  p = 1'b1;
         3'b101:  p = 1'b0;
         default: pe = 1'b0;
      endcase
      if (pe) begin
         b[n] = p;
         n++;
      end
      b[n] = 1'b1;
      n++;
      if (e.sb) begin
         b[n] = 1'b1;
         n++;
      end
   endfunction

   // Present a word from a negedge, wait (bounded) for in_ready, record the
   // expected frame at the moment the accept edge is known to follow, then
   // return just after that edge. Without keep_valid the inputs are scrambled
   // straight after accept to show the frame no longer depends on them.
   task automatic drive(input bit s, input logic [8:0] d, input logic [2:0] pt,
                        input logic stp, input bit keep_valid, output bit ok);
      exp_t e;
      int   n;
      @(negedge clk);
      if (s) begin
         d7_data = d[6:0]; d7_pt = pt; d7_sb = stp; d7_valid = 1'b1;
      end else begin
         d8_data = d[7:0]; d8_pt = pt; d8_sb = stp; d8_valid = 1'b1;
      end
      n = 0;
      while (rdy_of(s) !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (rdy_of(s) !== 1'b1) begin
         ok = 1'b0;
         d7_valid = 1'b0;
         d8_valid = 1'b0;
         return;
      end
      e.data = d; e.pt = pt; e.sb = stp; e.sel7 = s;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (!keep_valid) begin
         if (s) begin
            d7_valid = 1'b0; d7_data = 7'($urandom); d7_pt = 3'($urandom); d7_sb = ~stp;
         end else begin
            d8_valid = 1'b0; d8_data = 8'($urandom); d8_pt = 3'($urandom); d8_sb = ~stp;
         end
      end
      ok = 1'b1;
   endtask

   // Capture one frame from tx. gap = negedges waited until tx went low,
   // len = cycles before frame_done, bits = tx sampled mid-bit.
   // hold_ok: tx constant within each bit time; flags_ok: busy=1 and
   // in_ready=0 every frame cycle; end_ok: tx=1, busy=0, in_ready=1 with
   // frame_done.
   task automatic capture(input bit s, output int gap, output int len,
                          output logic [15:0] bits, output bit hold_ok,
                          output bit flags_ok, output bit end_ok);
      logic wave [0:127];
      int   cpb;
      cpb      = s ? 2 : 4;
      gap      = 0;
      len      = 0;
      bits     = '0;
      hold_ok  = 1'b1;
      flags_ok = 1'b1;
      end_ok   = 1'b0;
      for (int i = 0; i < 128; i++) wave[i] = 1'b1;
      do begin
         @(negedge clk);
         gap++;
      end while (tx_of(s) !== 1'b0 && gap < 400);
      if (tx_of(s) !== 1'b0) return;
      for (int c = 1; c <= 128; c++) begin
         if (c > 1) @(negedge clk);
         if (done_of(s) === 1'b1) begin
            len    = c - 1;
            end_ok = (tx_of(s) === 1'b1) && (busy_of(s) === 1'b0) && (rdy_of(s) === 1'b1);
            break;
         end
         wave[c-1] = tx_of(s);
         if (busy_of(s) !== 1'b1 || rdy_of(s) !== 1'b0) flags_ok = 1'b0;
      end
      for (int k = 0; k < 16 && (k + 1) * cpb <= len; k++) begin
         bits[k] = wave[k*cpb + cpb/2];
         for (int j = 0; j < cpb; j++)
            if (wave[k*cpb + j] !== wave[k*cpb]) hold_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({tx8, busy8, rdy8, done8} !== 4'b1010) begin
         failures++;
         $display("FAIL reset8 tx/busy/rdy/done got=%b want=1010", {tx8, busy8, rdy8, done8});
      end
      checks++;
      if ({tx7, busy7, rdy7, done7} !== 4'b1010) begin
         failures++;
         $display("FAIL reset7 tx/busy/rdy/done got=%b want=1010", {tx7, busy7, rdy7, done7});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx8, busy8, rdy8, done8, tx7, busy7, rdy7, done7} !== 8'b1010_1010) begin
         failures++;
         $display("FAIL idle_after_release got=%b want=10101010",
                  {tx8, busy8, rdy8, done8, tx7, busy7, rdy7, done7});
      end
   endtask

   task automatic test_t1_even();
      bit ok, h, f, en;
      int gap, len, nb;
      logic [15:0] bits, eb;
      exp_t e;
      drive(1'b0, 9'h0A5, 3'b010, 1'b0, 1'b0, ok);
      capture(1'b0, gap, len, bits, h, f, en);
      checks++;
      if (!ok || sb_q.size() == 0) begin
         failures++;
         $display("FAIL t1_accept got=%0d want=1", ok);
         return;
      end
      e = sb_q.pop_front();
      model(e, eb, nb);
      checks++;
      if (len !== 44) begin
         failures++;
         $display("FAIL t1_len got=%0d want=44", len);
      end
      checks++;
      if (bits !== 16'h054A) begin
         failures++;
         $display("FAIL t1_bits got=%h want=054a", bits);
      end
      checks++;
      if (bits !== eb) begin
         failures++;
         $display("FAIL t1_model got=%h want=%h", bits, eb);
      end
      checks++;
      if ({h, f, en} !== 3'b111) begin
         failures++;
         $display("FAIL t1_shape hold/flags/end got=%b want=111", {h, f, en});
      end
   endtask

   task automatic test_t2_odd();
      logic [8:0] dt [0:1] = '{9'h0A5, 9'h000};
      bit ok, h, f, en;
      int gap, len, nb;
      logic [15:0] bits, eb;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, dt[i], 3'b001, 1'b1, 1'b0, ok);
         capture(1'b0, gap, len, bits, h, f, en);
         checks++;
         if (!ok || sb_q.size() == 0) begin
            failures++;
            $display("FAIL t2_accept word=%0d got=%0d want=1", i, ok);
            continue;
         end
         e = sb_q.pop_front();
         model(e, eb, nb);
         checks++;
         if (len !== 48) begin
            failures++;
            $display("FAIL t2_len word=%0d got=%0d want=48", i, len);
         end
         checks++;
         if (bits[9] !== 1'b1) begin
            failures++;
            $display("FAIL t2_parity word=%0d got=%b want=1", i, bits[9]);
         end
         checks++;
         if (bits !== eb) begin
            failures++;
            $display("FAIL t2_bits word=%0d got=%h want=%h", i, bits, eb);
         end
         checks++;
         if ({h, f, en} !== 3'b111) begin
            failures++;
            $display("FAIL t2_shape word=%0d got=%b want=111", i, {h, f, en});
         end
      end
   endtask

   task automatic test_t3_modes();
      logic [8:0] dt [0:4] = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h000, 9'h000};
      logic [2:0] pt [0:4] = '{3'b000, 3'b011, 3'b111, 3'b100, 3'b101};
      int         lw [0:4] = '{40, 40, 40, 44, 44};
      bit ok, h, f, en;
      int gap, len, nb;
      logic [15:0] bits, eb;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, dt[i], pt[i], 1'b0, 1'b0, ok);
         capture(1'b0, gap, len, bits, h, f, en);
         checks++;
         if (!ok || sb_q.size() == 0) begin
            failures++;
            $display("FAIL t3_accept mode=%b got=%0d want=1", pt[i], ok);
            continue;
         end
         e = sb_q.pop_front();
         model(e, eb, nb);
         checks++;
         if (len !== lw[i]) begin
            failures++;
            $display("FAIL t3_len mode=%b got=%0d want=%0d", pt[i], len, lw[i]);
         end
         checks++;
         if (bits !== eb) begin
            failures++;
            $display("FAIL t3_bits mode=%b got=%h want=%h", pt[i], bits, eb);
         end
         checks++;
         if ({h, f, en} !== 3'b111) begin
            failures++;
            $display("FAIL t3_shape mode=%b got=%b want=111", pt[i], {h, f, en});
         end
      end
   endtask

   // in_valid held high across three words; the next word is presented while
   // the current frame runs. Then one more word with inputs scrambled
   // mid-frame.
   task automatic test_back_to_back();
      logic [8:0] dt [0:3] = '{9'h03C, 9'h0C3, 9'h081, 9'h07E};
      logic [2:0] pt [0:3] = '{3'b010, 3'b001, 3'b000, 3'b101};
      logic       st [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
      bit ok [0:3];
      fork
         begin
            for (int i = 0; i < 4; i++)
               drive(1'b0, dt[i], pt[i], st[i], (i < 2), ok[i]);
         end
         begin
            bit h, f, en;
            int gap, len, nb;
            logic [15:0] bits, eb;
            exp_t e;
            for (int i = 0; i < 4; i++) begin
               capture(1'b0, gap, len, bits, h, f, en);
               checks++;
               if (sb_q.size() == 0) begin
                  failures++;
                  $display("FAIL b2b_queue frame=%0d got=empty want=entry", i);
                  continue;
               end
               e = sb_q.pop_front();
               model(e, eb, nb);
               checks++;
               if (len !== nb * 4) begin
                  failures++;
                  $display("FAIL b2b_len frame=%0d got=%0d want=%0d", i, len, nb * 4);
               end
               checks++;
               if (bits !== eb) begin
                  failures++;
                  $display("FAIL b2b_bits frame=%0d got=%h want=%h", i, bits, eb);
               end
               checks++;
               if ({h, f, en} !== 3'b111) begin
                  failures++;
                  $display("FAIL b2b_shape frame=%0d got=%b want=111", i, {h, f, en});
               end
               if (i == 1 || i == 2) begin
                  checks++;
                  if (gap !== 1) begin
                     failures++;
                     $display("FAIL b2b_gap frame=%0d got=%0d want=1", i, gap);
                  end
               end
            end
         end
      join
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ok[i] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept word=%0d got=%0d want=1", i, ok[i]);
         end
      end
      // Nothing left over: every word sent exactly once.
      repeat (10) @(negedge clk);
      checks++;
      if (sb_q.size() !== 0 || tx8 !== 1'b1 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_no_dup got=q%0d/tx%b/busy%b want=q0/tx1/busy0",
                  sb_q.size(), tx8, busy8);
      end
   endtask

   task automatic test_midframe_reset();
      bit ok, h, f, en, quiet;
      int gap, len, nb;
      logic [15:0] bits, eb;
      exp_t e;
      drive(1'b0, 9'h0F0, 3'b010, 1'b0, 1'b0, ok);
      repeat (18) @(negedge clk);
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL t5_in_frame got=%b want=1", busy8);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({tx8, busy8, rdy8, done8} !== 4'b1010) begin
         failures++;
         $display("FAIL t5_async tx/busy/rdy/done got=%b want=1010", {tx8, busy8, rdy8, done8});
      end
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      quiet = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         failures++;
         $display("FAIL t5_no_resume got=%b want=1", quiet);
      end
      drive(1'b0, 9'h096, 3'b001, 1'b1, 1'b0, ok);
      capture(1'b0, gap, len, bits, h, f, en);
      checks++;
      if (!ok || sb_q.size() == 0) begin
         failures++;
         $display("FAIL t5_accept got=%0d want=1", ok);
         return;
      end
      e = sb_q.pop_front();
      model(e, eb, nb);
      checks++;
      if (len !== 48 || bits !== eb) begin
         failures++;
         $display("FAIL t5_frame got=len%0d/%h want=len48/%h", len, bits, eb);
      end
      checks++;
      if ({h, f, en} !== 3'b111) begin
         failures++;
         $display("FAIL t5_shape got=%b want=111", {h, f, en});
      end
   endtask

   task automatic test_t6_w7();
      logic [8:0] dt [0:1] = '{9'h055, 9'h07F};
      logic [2:0] pt [0:1] = '{3'b010, 3'b001};
      logic       st [0:1] = '{1'b0, 1'b1};
      int         lw [0:1] = '{20, 22};
      bit ok, h, f, en;
      int gap, len, nb;
      logic [15:0] bits, eb;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, dt[i], pt[i], st[i], 1'b0, ok);
         capture(1'b1, gap, len, bits, h, f, en);
         checks++;
         if (!ok || sb_q.size() == 0) begin
            failures++;
            $display("FAIL t6_accept word=%0d got=%0d want=1", i, ok);
            continue;
         end
         e = sb_q.pop_front();
         model(e, eb, nb);
         checks++;
         if (len !== lw[i]) begin
            failures++;
            $display("FAIL t6_len word=%0d got=%0d want=%0d", i, len, lw[i]);
         end
         checks++;
         if (bits !== eb) begin
            failures++;
            $display("FAIL t6_bits word=%0d got=%h want=%h", i, bits, eb);
         end
         if (i == 0) begin
            checks++;
            if (bits[8] !== 1'b0) begin
               failures++;
               $display("FAIL t6_parity got=%b want=0", bits[8]);
            end
         end
         checks++;
         if ({h, f, en} !== 3'b111) begin
            failures++;
            $display("FAIL t6_shape word=%0d got=%b want=111", i, {h, f, en});
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_t1_even();
      test_t2_odd();
      test_t3_modes();
      test_back_to_back();
      test_midframe_reset();
      test_t6_w7();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
